// File: rtl/ov7670_sccb_pkg.sv
// Shared constants, FSM encoding and pin decode for the OV7670 SCCB init sequencer.
// OV7670_SOFT_RESET_EN adds the COM7 soft-reset states to the FSM.
package ov7670_sccb_pkg;
  localparam logic [7:0]  SCCB_WR_ID = 8'h42;
  localparam logic [15:0] SCCB_END   = 16'hFFFF;
  localparam logic [7:0]  COM7_ADDR  = 8'h12;
  localparam logic [7:0]  COM7_RESET = 8'h80;

  typedef enum logic [3:0] {
    IDLE, FETCH, START, BYTE, STOP, GAP, DONE
`ifdef OV7670_SOFT_RESET_EN
    , RST_WR, RST_WAIT
`endif
  } state_t;

  // {scl, sda} for a given state and quarter; b is the current data bit.
  function automatic logic [1:0] bus_pins(state_t st, logic [1:0] q, logic b);
    case (st)
      START:   bus_pins = (q == 2'd0) ? 2'b11 : (q == 2'd3) ? 2'b00 : 2'b10;
      BYTE:    bus_pins = {q[1], b};
      STOP:    bus_pins = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b10 : 2'b11;
      default: bus_pins = 2'b11;
    endcase
  endfunction
endpackage

// File: rtl/ov7670_sccb_init_if.sv
// Control/status and SCCB pin bundle of the OV7670 init sequencer.
interface ov7670_sccb_init_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] entry_idx;
  logic       scl;
  logic       sda;

  modport master (input start, output busy, done, entry_idx, scl, sda);
  modport slave  (output start, input busy, done, entry_idx, scl, sda);
endinterface

// File: rtl/ov7670_reg_rom.sv
// Combinational register table: {reg_addr, data} per entry, terminated by SCCB_END.
// ROM_SEL 0 is the camera list; 1 and 2 are short bring-up tables.
module ov7670_reg_rom
  import ov7670_sccb_pkg::*;
#(
  parameter int ROM_SEL = 0
) (
  input  logic [7:0]  idx,
  output logic [15:0] word
);
  always_comb begin
    word = SCCB_END;
    case (ROM_SEL)
      1: case (idx)
           8'd0:    word = 16'h1204;
           8'd1:    word = 16'h40D0;
           default: ;
         endcase
      2: ;
      default: case (idx)
           8'd0:    word = 16'h1204;  // COM7: RGB output
           8'd1:    word = 16'h40D0;  // COM15: RGB565, full range
           8'd2:    word = 16'h3A04;  // TSLB
           8'd3:    word = 16'h8C00;  // RGB444 off
           8'd4:    word = 16'h1101;  // CLKRC prescale
           8'd5:    word = 16'h0C00;  // COM3
           8'd6:    word = 16'h3E00;  // COM14
           default: ;
         endcase
    endcase
  end
endmodule

// File: rtl/ov7670_sccb_init.sv
// SCCB power-up sequencer for the OV7670: one START/ID/addr/data/STOP/GAP write per ROM entry.
// Define OV7670_SOFT_RESET_EN to precede the table with a COM7 soft reset and a settle wait.
module ov7670_sccb_init
  import ov7670_sccb_pkg::*;
#(
  parameter int QTR_CYC      = 250,
  parameter int GAP_QTRS     = 4,
  parameter int RST_WAIT_CYC = 100_000,
  parameter int ROM_SEL      = 0
) (
  input logic                clk,
  input logic                reset,
  ov7670_sccb_init_if.master bus
);
  localparam int QW = $clog2(QTR_CYC);

  state_t        state, state_d;
  logic [QW-1:0] qcnt, qcnt_d;
  logic [7:0]    qidx, qidx_d, entry, entry_d, byte_val;
  logic [3:0]    bit_cnt, bit_d;
  logic [1:0]    byte_cnt, byte_d, pins, pins_d;
  logic [15:0]   word, word_d, rom_word;
  logic          busy, busy_d, done, done_d, qtick, last_q, bit_val;
`ifdef OV7670_SOFT_RESET_EN
  localparam int WW = $clog2(RST_WAIT_CYC + 1);
  logic          rst_phase, rst_phase_d;
  logic [WW-1:0] wcnt, wcnt_d;
`endif

  ov7670_reg_rom #(.ROM_SEL(ROM_SEL)) u_rom (.idx(entry), .word(rom_word));

  assign qtick  = (qcnt == QW'(QTR_CYC - 1));
  assign last_q = (qidx == ((state == GAP) ? 8'(GAP_QTRS - 1) : 8'd3));

  always_comb begin
    state_d = state;
    qcnt_d  = '0;
    qidx_d  = qidx;
    bit_d   = bit_cnt;
    byte_d  = byte_cnt;
    word_d  = word;
    entry_d = entry;
    done_d  = done;
`ifdef OV7670_SOFT_RESET_EN
    rst_phase_d = rst_phase;
    wcnt_d      = '0;
`endif
    if (state inside {START, BYTE, STOP, GAP}) begin
      qcnt_d = qtick ? '0 : qcnt + QW'(1);
      if (qtick) qidx_d = last_q ? 8'd0 : qidx + 8'd1;
    end
    case (state)
      IDLE: if (bus.start) begin
        entry_d = '0;
        done_d  = 1'b0;
`ifdef OV7670_SOFT_RESET_EN
        state_d = RST_WR;
`else
        state_d = FETCH;
`endif
      end
      FETCH: begin
        word_d  = rom_word;
        qidx_d  = '0;
        state_d = (rom_word == SCCB_END) ? DONE : START;
      end
      START: if (qtick && last_q) begin
        bit_d   = '0;
        byte_d  = '0;
        state_d = BYTE;
      end
      BYTE: if (qtick && last_q) begin
        if (bit_cnt == 4'd8) begin
          bit_d = '0;
          if (byte_cnt == 2'd2) state_d = STOP;
          else                  byte_d  = byte_cnt + 2'd1;
        end else begin
          bit_d = bit_cnt + 4'd1;
        end
      end
      STOP: if (qtick && last_q) state_d = GAP;
      GAP: if (qtick && last_q) begin
`ifdef OV7670_SOFT_RESET_EN
        if (rst_phase) begin
          rst_phase_d = 1'b0;
          state_d     = RST_WAIT;
        end else
`endif
        // entry 255 is the last slot: no wrap back to 0
        if (entry == 8'hFF) state_d = DONE;
        else begin
          entry_d = entry + 8'd1;
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`ifdef OV7670_SOFT_RESET_EN
      RST_WR: begin
        word_d      = {COM7_ADDR, COM7_RESET};
        rst_phase_d = 1'b1;
        qidx_d      = '0;
        state_d     = START;
      end
      RST_WAIT: begin
        if (wcnt == WW'(RST_WAIT_CYC - 1)) state_d = FETCH;
        else                               wcnt_d  = wcnt + WW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next-state view so they line up with the state register.
  always_comb begin
    case (byte_d)
      2'd0:    byte_val = SCCB_WR_ID;
      2'd1:    byte_val = word_d[15:8];
      default: byte_val = word_d[7:0];
    endcase
    bit_val = (bit_d == 4'd8) ? 1'b1 : byte_val[3'd7 - bit_d[2:0]];
    pins_d  = bus_pins(state_d, qidx_d[1:0], bit_val);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      qidx     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      word     <= '0;
      entry    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pins     <= 2'b11;
`ifdef OV7670_SOFT_RESET_EN
      rst_phase <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      state    <= state_d;
      qcnt     <= qcnt_d;
      qidx     <= qidx_d;
      bit_cnt  <= bit_d;
      byte_cnt <= byte_d;
      word     <= word_d;
      entry    <= entry_d;
      busy     <= busy_d;
      done     <= done_d;
      pins     <= pins_d;
`ifdef OV7670_SOFT_RESET_EN
      rst_phase <= rst_phase_d;
      wcnt      <= wcnt_d;
`endif
    end
  end

  assign bus.scl       = pins[1];
  assign bus.sda       = pins[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.entry_idx = entry;
endmodule

// File: doc/ov7670_sccb_init.md
# ov7670_sccb_init

Power-up configuration sequencer for the OV7670 camera's SCCB (I2C-like) control port. On a start pulse it walks a register table and issues one 3-phase SCCB write per entry: device ID, register address, data. Writes are issued in table order until an end marker. It drives the top-level `scl`/`sda` pins. It runs on the same system clock as the UART path and must finish before the capture and VGA datapath is trusted.

## Interface

- `QTR_CYC`, default 250: clk cycles per SCL quarter-period (100 MHz / 400 kHz gives 100 kHz SCL); legal range ≥2.
- `GAP_QTRS`, default 4: idle quarters between consecutive transactions.
- `RST_WAIT_CYC`, default 100_000: post-soft-reset wait in clk cycles; used only with the macro.
- `clk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin the configuration sequence.
- `busy`  out  1  high from the cycle after an accepted `start` until sequence end.
- `done`  out  1  sticky high after the end marker is reached; cleared by the next accepted `start`.
- `entry_idx`  out  8  index of the table entry currently being written.
- `scl`  out  1  SCCB clock, push-pull; idle high.
- `sda`  out  1  SCCB data, push-pull; idle high; the 9th (don't-care) bit is driven as 1.

## Operation

- Table entry = 16 bits {reg_addr[15:8], data[7:0]}. Entry 16'hFFFF = end marker.
- Transaction order: START, byte 8'h42, byte reg_addr, byte data, STOP, then GAP. Each byte is 8 bits MSB-first followed by a 9th bit with sda=1.
- FSM states: IDLE, FETCH, START, BYTE, STOP, GAP, DONE. The macro adds RST_WR and RST_WAIT.
- IDLE: `start`=1 moves to FETCH (or RST_WR with the macro), sets `busy`, clears `done`, and sets `entry_idx`=0.
- FETCH: one cycle; registers the ROM word. The end marker goes to DONE; any other word goes to START.
- BYTE: 9-bit counter (0..8) and 2-bit byte counter (0..2). After byte 2, bit 8, go to STOP.
- GAP: `GAP_QTRS` quarters with scl=sda=1. Then `entry_idx`++ and go to FETCH.
- DONE: `busy`=0, `done`=1, then return to IDLE the same cycle (`done` stays high).
- `start` while `busy`=1 is ignored.
- If `entry_idx` reaches 255 and that entry is not the end marker, it is written and the sequence then ends as DONE. There is no wrap.
- No ACK sampling; the bus is write-only.

## Timing

- Quarter tick: a counter counts 0..QTR_CYC-1 and pulses `qtick`. All state and pin changes happen only on `qtick`, except the IDLE→FETCH and FETCH transitions, which are immediate.
- START quarters q0..q3, as (scl,sda): (1,1), (1,0), (1,0), (0,0).
- Bit quarters: q0 (0,bit), q1 (0,bit), q2 (1,bit), q3 (1,bit). sda changes only while scl=0.
- STOP quarters: (0,0), (1,0), (1,1), (1,1).
- One transaction = 4+27·4+4+GAP_QTRS quarters, which is 120 quarters (30000 cycles) at the defaults.
- `start` accepted at edge N gives `busy`=1 after N. The first scl/sda change (sda fall) is at quarter q1 of START.
- Reset values: scl=1, sda=1, `busy`=0, `done`=0, `entry_idx`=0, FSM=IDLE, counters 0.
- Reset asserted mid-transaction releases the pins to idle immediately (asynchronously) without a STOP. The next `start` restarts the sequence at entry 0.

## Configuration

- `OV7670_SOFT_RESET_EN` defined: after `start`, the block first issues a full write of COM7 (0x12)=0x80 in state RST_WR. It then waits `RST_WAIT_CYC` cycles with the bus idle (RST_WAIT) before FETCH of entry 0. `entry_idx` stays 0 throughout.
- Not defined: `start` goes directly to FETCH. RST_WR and RST_WAIT are absent, and `RST_WAIT_CYC` is unused.

## Structure

- Package `ov7670_sccb_pkg`:
  - `SCCB_WR_ID`=8'h42
  - `SCCB_END`=16'hFFFF
  - `COM7_ADDR`=8'h12
  - `COM7_RESET`=8'h80
  - the FSM state enum
- Sub-module `ov7670_reg_rom`: combinational (or 1-cycle registered, absorbed by FETCH) `entry_idx` → 16-bit word lookup containing the camera register list and terminated by `SCCB_END`.

## Test plan

The bench uses `QTR_CYC`=4 and `GAP_QTRS`=4 with a 3-entry test ROM {0x1204, 0x40D0, 0xFFFF}.

- **Single write:** pulse `start` → decoded SCCB bytes are 0x42,0x12,0x04 then 0x42,0x40,0xD0, each with a 9th bit of sda=1. After that, `busy` falls and `done`=1, at 2·120·4 cycles (plus FETCH cycles) after start.
- **Bit timing:** check sda never changes while scl=1 except at START (fall) and STOP (rise). START is (1,1)→(1,0)→(0,0); STOP is (0,0)→(1,0)→(1,1).
- **Start while busy:** pulse `start` again mid-transaction → no restart; `entry_idx` and byte sequence are unaffected. A pulse after `done` clears `done` and replays from entry 0.
- **Reset mid-byte:** assert `reset`=0 during byte 2 → scl=sda=1 and `busy`=0 without waiting for a clock. The next `start` writes 0x1204 first.
- **Immediate end:** ROM {0xFFFF} → `busy` pulses for 2 cycles and `done`=1, with no scl activity.
- **With `OV7670_SOFT_RESET_EN`** and `RST_WAIT_CYC`=50: the first transaction is 0x42,0x12,0x80; the bus stays idle for ≥50 cycles; then 0x42,0x12,0x04 follows.
